// File: rtl/twiddle64_mult_pipe_if.sv
// rtl/twiddle64_mult_pipe_if.sv - valid/ready sample stream bundle for the runtime twiddle multiplier
interface twiddle64_mult_pipe_if #(
  parameter int DATA_WIDTH = 14,
  parameter int LOG2N      = 6
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  din_real;
  logic signed [DATA_WIDTH-1:0]  din_imag;
  logic        [LOG2N-1:0]       tw_idx;
  logic                          inv;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH:0]    dout_real;
  logic signed [DATA_WIDTH:0]    dout_imag;

  modport master (
    output in_valid, din_real, din_imag, tw_idx, inv, out_ready,
    input  in_ready, out_valid, dout_real, dout_imag
  );

  modport slave (
    input  in_valid, din_real, din_imag, tw_idx, inv, out_ready,
    output in_ready, out_valid, dout_real, dout_imag
  );
endinterface

// File: rtl/twiddle64_mult_pipe.sv
// rtl/twiddle64_mult_pipe.sv - 3-stage complex multiply by W_N^k, k per sample, octant-folded ROM
// Define TWM_ROUND_EN for round-half-up on the final shift; otherwise the shift truncates (floor).
module twiddle64_mult_pipe #(
  parameter int DATA_WIDTH = 14,
  parameter int COEF_WIDTH = 16,
  parameter int LOG2N      = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  twiddle64_mult_pipe_if.slave bus
);

  localparam int  N    = 1 << LOG2N;
  localparam int  N8   = N / 8;
  localparam int  M    = N8 + 1;
  localparam int  RW   = (M > 1) ? $clog2(M) : 1;
  localparam int  FRAC = COEF_WIDTH - 2;
  localparam int  PW   = DATA_WIDTH + COEF_WIDTH;
  localparam int  SW   = PW + 1;
  localparam int  OW   = DATA_WIDTH + 1;
  localparam real PI   = 3.14159265358979323846;

`ifdef TWM_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(longint'(1) << (FRAC - 1));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  // First-octant cos/sin table, rounded half away from zero at elaboration
  logic signed [COEF_WIDTH-1:0] rom_c [M];
  logic signed [COEF_WIDTH-1:0] rom_s [M];

  for (genvar g = 0; g < M; g++) begin : g_rom
    localparam real ANG   = 2.0 * PI * g / N;
    localparam real SCALE = 2.0 ** FRAC;
    localparam int  CV    = $rtoi($cos(ANG) * SCALE + 0.5);
    localparam int  SV    = $rtoi($sin(ANG) * SCALE + 0.5);
    assign rom_c[g] = COEF_WIDTH'(CV);
    assign rom_s[g] = COEF_WIDTH'(SV);
  end

  logic en;
  logic v1_q, v2_q, v3_q;

  assign en            = bus.out_ready | ~v3_q;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3_q;

  // S1 combinational: index fold, ROM read, octant map
  logic        [LOG2N-1:0]      ke;
  logic        [LOG2N-1:0]      r_w;
  logic        [LOG2N-1:0]      rr;
  logic        [2:0]            oct;
  logic signed [COEF_WIDTH-1:0] c_sel, s_sel;
  logic signed [COEF_WIDTH-1:0] cos_t, sin_t;
  logic signed [COEF_WIDTH-1:0] wr_d, wi_d;

  always_comb begin
    ke    = bus.inv ? (LOG2N'(0) - bus.tw_idx) : bus.tw_idx;
    oct   = ke[LOG2N-1 -: 3];
    r_w   = ke & LOG2N'(N8 - 1);
    rr    = oct[0] ? (LOG2N'(N8) - r_w) : r_w;
    c_sel = rom_c[RW'(rr)];
    s_sel = rom_s[RW'(rr)];
    cos_t = c_sel;
    sin_t = s_sel;
    case (oct)
      3'd0: begin cos_t =  c_sel; sin_t =  s_sel; end
      3'd1: begin cos_t =  s_sel; sin_t =  c_sel; end
      3'd2: begin cos_t = -s_sel; sin_t =  c_sel; end
      3'd3: begin cos_t = -c_sel; sin_t =  s_sel; end
      3'd4: begin cos_t = -c_sel; sin_t = -s_sel; end
      3'd5: begin cos_t = -s_sel; sin_t = -c_sel; end
      3'd6: begin cos_t =  s_sel; sin_t = -c_sel; end
      default: begin cos_t = c_sel; sin_t = -s_sel; end
    endcase
    wr_d = cos_t;
    wi_d = -sin_t;
  end

  logic signed [DATA_WIDTH-1:0] xr1_q, xi1_q;
  logic signed [COEF_WIDTH-1:0] wr1_q, wi1_q;
  logic signed [PW-1:0]         p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0]         p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [SW-1:0]         sum_r, sum_i;
  logic signed [OW-1:0]         dout_r_d, dout_i_d;
  logic signed [OW-1:0]         dout_r_q, dout_i_q;

  always_comb begin
    p_rr_d = PW'(xr1_q) * PW'(wr1_q);
    p_ii_d = PW'(xi1_q) * PW'(wi1_q);
    p_ri_d = PW'(xr1_q) * PW'(wi1_q);
    p_ir_d = PW'(xi1_q) * PW'(wr1_q);
  end

  always_comb begin
    sum_r    = SW'(p_rr_q) - SW'(p_ii_q) + RND;
    sum_i    = SW'(p_ri_q) + SW'(p_ir_q) + RND;
    dout_r_d = OW'(sum_r >>> FRAC);
    dout_i_d = OW'(sum_i >>> FRAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      dout_r_q <= '0;
      dout_i_q <= '0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        dout_r_q <= dout_r_d;
        dout_i_q <= dout_i_d;
      end
    end
  end

  // Datapath registers need no reset; only valid-qualified contents are ever observed
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      xr1_q <= bus.din_real;
      xi1_q <= bus.din_imag;
      wr1_q <= wr_d;
      wi1_q <= wi_d;
    end
    if (en && v1_q) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
    end
  end

  assign bus.dout_real = dout_r_q;
  assign bus.dout_imag = dout_i_q;

endmodule

// File: tb/tb_twiddle64_mult_pipe.sv
// tb/tb_twiddle64_mult_pipe.sv - scoreboard bench for twiddle64_mult_pipe (default DW=14, CW=16, N=64)
module tb_twiddle64_mult_pipe;
  localparam int  DW  = 14;
  localparam int  CW  = 16;
  localparam int  L2N = 6;
  localparam int  N   = 64;
  localparam real PI  = 3.14159265358979323846;
  localparam real ONE = 16384.0;
`ifdef TWM_ROUND_EN
  localparam longint RND = 8192;
`else
  localparam longint RND = 0;
`endif

  typedef struct {
    int r;
    int i;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  twiddle64_mult_pipe_if #(.DATA_WIDTH(DW), .LOG2N(L2N)) bus ();

  twiddle64_mult_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .LOG2N(L2N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint round_away(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    else          return -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic exp_t model(input int k, input bit iv, input int xr, input int xi);
    exp_t   e;
    int     ke;
    real    ang;
    longint wr, wi, sr, si;
    ke  = iv ? (N - k) % N : k;
    ang = 2.0 * PI * ke / N;
    wr  = round_away($cos(ang) * ONE);
    wi  = -round_away($sin(ang) * ONE);
    sr  = longint'(xr) * wr - longint'(xi) * wi + RND;
    si  = longint'(xr) * wi + longint'(xi) * wr + RND;
    e.r = int'(sr >>> 14);
    e.i = int'(si >>> 14);
    assert (e.r >= -(1 << DW) && e.r < (1 << DW) && e.i >= -(1 << DW) && e.i < (1 << DW));
    return e;
  endfunction

  task automatic send_one(input int k, input bit iv, input int xr, input int xi,
                          output int lat, output int yr, output int yi);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.tw_idx    = L2N'(k);
    bus.inv       = iv;
    bus.din_real  = DW'(xr);
    bus.din_imag  = DW'(xi);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    yr = bus.dout_real;
    yi = bus.dout_imag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.tw_idx = '0;
    bus.inv = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.dout_real !== '0 || bus.dout_imag !== '0) begin
      errors++; $display("FAIL reset_dout got (%0d,%0d) want (0,0)", bus.dout_real, bus.dout_imag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_quarter();
    int lat, yr, yi;
    send_one(16, 1'b0, 1000, 200, lat, yr, yi);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL k16_latency got %0d want 3", lat); end
    checks++;
    if (yr !== 200 || yi !== -1000) begin errors++; $display("FAIL k16_fwd got (%0d,%0d) want (200,-1000)", yr, yi); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL k16_single_beat got out_valid %0b want 0", bus.out_valid); end
    send_one(16, 1'b1, 1000, 200, lat, yr, yi);
    checks++;
    if (yr !== -200 || yi !== 1000) begin errors++; $display("FAIL k16_inv got (%0d,%0d) want (-200,1000)", yr, yi); end
  endtask

  task automatic test_index0();
    int lat, yr, yi;
    send_one(0, 1'b0, -8192, -8192, lat, yr, yi);
    checks++;
    if (yr !== -8192 || yi !== -8192) begin errors++; $display("FAIL k0_neg got (%0d,%0d) want (-8192,-8192)", yr, yi); end
    send_one(0, 1'b0, 8191, 8191, lat, yr, yi);
    checks++;
    if (yr !== 8191 || yi !== 8191) begin errors++; $display("FAIL k0_pos got (%0d,%0d) want (8191,8191)", yr, yi); end
    send_one(0, 1'b1, 8191, -8192, lat, yr, yi);
    checks++;
    if (yr !== 8191 || yi !== -8192) begin errors++; $display("FAIL k0_inv got (%0d,%0d) want (8191,-8192)", yr, yi); end
  endtask

  task automatic test_rounding();
    int lat, yr, yi;
    int wr_r, wr_i;
`ifdef TWM_ROUND_EN
    wr_r = 5792;
`else
    wr_r = 5791;
`endif
    wr_i = -5792;
    send_one(8, 1'b0, 8191, 0, lat, yr, yi);
    checks++;
    if (yr !== wr_r || yi !== wr_i) begin errors++; $display("FAIL k8_round got (%0d,%0d) want (%0d,%0d)", yr, yi, wr_r, wr_i); end
  endtask

  task automatic test_backpressure();
    int   sent, got, cyc, cur_k, pxr, pxi;
    bit   pend, piv, stall_prev;
    int   held_r, held_i, yr, yi;
    exp_t e;
    sent = 0; got = 0; cyc = 0; pend = 0; stall_prev = 0; held_r = 0; held_i = 0;
    cur_k = 0; piv = 0; pxr = 0; pxi = 0;
    while (got < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        checks++;
        if (int'(bus.dout_real) !== held_r || int'(bus.dout_imag) !== held_i || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stall_stable got (%0d,%0d,v%0b) want (%0d,%0d,v1)",
                             bus.dout_real, bus.dout_imag, bus.out_valid, held_r, held_i);
        end
      end
      bus.out_ready = ($urandom_range(1, 0) == 1);
      if (!pend && sent < 64 && $urandom_range(3, 0) != 0) begin
        pend = 1'b1;
        cur_k = sent;
        piv = ($urandom_range(1, 0) == 1);
        pxr = int'($urandom_range(16383, 0)) - 8192;
        pxi = int'($urandom_range(16383, 0)) - 8192;
        bus.tw_idx = L2N'(cur_k);
        bus.inv = piv;
        bus.din_real = DW'(pxr);
        bus.din_imag = DW'(pxi);
      end
      bus.in_valid = pend;
      #1;
      checks++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        errors++; $display("FAIL bp_in_ready got %0b want %0b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready) begin
        yr = bus.dout_real;
        yi = bus.dout_imag;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_unexpected_output got (%0d,%0d) want none", yr, yi);
        end else begin
          e = sb.pop_front();
          if (yr !== e.r || yi !== e.i) begin
            errors++; $display("FAIL bp_data #%0d got (%0d,%0d) want (%0d,%0d)", got, yr, yi, e.r, e.i);
          end
        end
        got++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_r = bus.dout_real;
      held_i = bus.dout_imag;
      if (pend && bus.in_ready) begin
        sb.push_back(model(cur_k, piv, pxr, pxi));
        sent++;
        pend = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got !== 64 || sb.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d outputs (%0d pending) want 64 (0)", got, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    int   lat, yr, yi, stale;
    exp_t e;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.tw_idx = L2N'(5 + i);
      bus.inv = 1'b0;
      bus.din_real = DW'(1234 + i);
      bus.din_imag = DW'(-777);
      sb.push_back(model(5 + i, 1'b0, 1234 + i, -777));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.dout_real !== '0 || bus.dout_imag !== '0) begin
      errors++; $display("FAIL midreset_clear got (v%0b,%0d,%0d) want (v0,0,0)", bus.out_valid, bus.dout_real, bus.dout_imag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release got (rdy%0b,v%0b) want (rdy1,v0)", bus.in_ready, bus.out_valid);
    end
    e = model(32, 1'b0, 300, -700);
    send_one(32, 1'b0, 300, -700, lat, yr, yi);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL midreset_latency got %0d want 3", lat); end
    checks++;
    if (yr !== e.r || yi !== e.i || yr !== -300 || yi !== 700) begin
      errors++; $display("FAIL midreset_data got (%0d,%0d) want (-300,700)", yr, yi);
    end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL midreset_stale got %0d extra outputs want 0", stale); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_quarter();
    test_index0();
    test_rounding();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twiddle64_mult_pipe.md
# twiddle64_mult_pipe

Pipelined, runtime-indexed complex twiddle multiplier for the FFT datapath. Each sample is multiplied by W_N^k = exp(-j·2πk/N), with k selected per sample. Coefficients come from a first-octant ROM (k = 0..N/8) plus octant folding, and the block exposes a valid/ready stream interface. It sits between butterfly stages where the twiddle varies per sample. It generalises the fixed-constant shift-add twiddle blocks to any N, any data/coefficient width, and a conjugate (inverse-FFT) mode.

## Interface
- DATA_WIDTH, 14, signed input component width.
- COEF_WIDTH, 16, signed coefficient width; COEF_WIDTH-2 fractional bits, so 1.0 = 2^(COEF_WIDTH-2).
- LOG2N, 6, log2 of FFT size N. Must be ≥ 3.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the input this cycle.
- din_real, din_imag  in  DATA_WIDTH each  input sample.
- tw_idx  in  LOG2N  twiddle index k.
- inv  in  1  1 = use conj(W^k), i.e. index (N-k) mod N.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- dout_real, dout_imag  out  DATA_WIDTH+1 each  product, signed.

## Operation
- ROM: M = N/8 + 1 entries, r = 0..N/8. Entry r holds c[r] = round(cos(2πr/N)·2^(CW-2)) and s[r] = round(sin(2πr/N)·2^(CW-2)). ROM is computed at elaboration with $cos/$sin. Half-away rounding applies to ROM contents only.
- Effective index: ke = inv ? (N-k) mod N : k.
- Octant split: o = ke[LOG2N-1:LOG2N-3], r = ke[LOG2N-4:0].
- Odd octants use rr = N/8 - r; even octants use rr = r. Set c = c[rr], s = s[rr].
- Octant mapping, given as (cosθ, sinθ):
  - o=0: (c, s)
  - o=1: (s, c)
  - o=2: (-s, c)
  - o=3: (-c, s)
  - o=4: (-c, -s)
  - o=5: (-s, -c)
  - o=6: (s, -c)
  - o=7: (c, -s)
- Twiddle: wr = cosθ, wi = -sinθ.
- Arithmetic, full precision:
  - yr = xr·wr - xi·wi
  - yi = xr·wi + xi·wr
  - Each sum is held at DATA_WIDTH+COEF_WIDTH+1 bits, then shifted right by COEF_WIDTH-2 with the rounding mode below, then taken as DATA_WIDTH+1 bits.
  - Overflow is impossible, since |y| ≤ √2·2^(DATA_WIDTH-1). The bench asserts this; no saturation logic.
- Index 0 is exact: output equals input, sign-extended.

## Timing
- 3-stage pipeline, latency 3 cycles from accept to out_valid when unstalled.
  - S1: register inputs, fold index, ROM read, octant map.
  - S2: four signed products.
  - S3: add/sub, round, output register.
- Global advance enable: en = out_ready | ~out_valid. in_ready = en.
- Accept occurs when in_valid & in_ready.
- Stalls:
  - While out_valid & ~out_ready, all stages hold.
  - dout_* and out_valid stay stable.
  - No sample is dropped or duplicated.
- Bubbles propagate as valid=0. Full throughput is 1 sample/cycle with out_ready held high.
- Reset (async assert, any time, including mid-stream):
  - All stage valid flags go to 0, so out_valid = 0.
  - dout_real = dout_imag = 0.
  - in_ready = 1 from the first cycle after deassert.
  - In-flight samples are discarded.
- Data registers do not need reset except the output registers.

## Configuration
- TWM_ROUND_EN defined: S3 adds 2^(CW-3) before the arithmetic right shift (round half up, toward +∞ on ties).
- TWM_ROUND_EN undefined: plain arithmetic right shift (floor/truncation).
- Latency and interface are identical in both builds.

## Test plan
All scenarios use defaults (DW=14, CW=16, N=64); 1.0 = 16384, c[8] = s[8] = 11585.
- k=16, inv=0, x=(1000,200) → y=(200,-1000) after exactly 3 cycles.
- k=16, inv=1, x=(1000,200) → y=(-200,1000).
- k=0, x=(-8192,-8192) and x=(8191,8191) → identical values on 15-bit outputs.
- k=8, x=(8191,0):
  - with TWM_ROUND_EN → y=(5792,-5792)
  - without → y=(5791,-5792)
- Backpressure:
  - Stream k=0..63 with random x and random out_ready at ~50%.
  - Output order and values must match a real-valued model within ±1 LSB (±0 for k ∈ {0,16,32,48}).
  - in_ready is low only when out_valid & ~out_ready.
  - dout is stable during stalls.
- Assert rst_n low with 3 samples in flight → out_valid and dout go to 0 immediately. After release, the first new sample emerges 3 cycles after acceptance, with no stale outputs.
